// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: four-channel DMA request arbiter with fixed/rotating priority and HRQ/HLDA handshake
//   CLK, RESET         clock, async active-high reset
//   DREQ, maskReg      channel requests and per-channel masks (1 = ignore)
//   rotatePriority     0 = fixed (ch0 highest), 1 = rotate after each completed service
//   HLDA, serviceDone  hold acknowledge from CPU, end-of-service pulse from timing block
//   HRQ, DACK          registered hold request and one-hot acknowledge
//   activeChannel      registered granted channel index
//   busy               high whenever not idle
module dma_priority_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              rotatePriority,
  input  logic              HLDA,
  input  logic              serviceDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [1:0]        activeChannel,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;
  state_t state, state_n;
  logic hrq_n;
  logic [NUM_CH-1:0] dack_n, pending;
  logic [1:0] active_n, lowest, lowest_n, base, winner;
  assign pending = DREQ & ~maskReg;
  assign base = rotatePriority ? lowest : 2'd3;
  assign busy = state != IDLE;
  // Scan from furthest to nearest so the channel closest after base wins.
  always_comb begin
    winner = base;
    for (int i = NUM_CH; i >= 1; i--)
      if (pending[2'(base + 2'(i))]) winner = 2'(base + 2'(i));
  end
  always_comb begin
    state_n = state;
    hrq_n = HRQ;
    dack_n = DACK;
    active_n = activeChannel;
    lowest_n = lowest;
    case (state)
      IDLE: begin
        hrq_n = |pending;
        dack_n = '0;
        state_n = |pending ? REQ : IDLE;
      end
      REQ: begin
        hrq_n = |pending;
        state_n = !(|pending) ? IDLE : HLDA ? GRANT : REQ;
        if (HLDA && |pending) begin
          active_n = winner;
          dack_n = '0;
          dack_n[winner] = 1'b1;
        end
      end
      GRANT: begin
        // Completion, mask-out and bus revoke all drop the grant; only completion rotates.
        if (serviceDone || !HLDA || maskReg[activeChannel]) begin
          hrq_n = 1'b0;
          dack_n = '0;
          state_n = HLDA ? RELEASE : IDLE;
          if (serviceDone && rotatePriority) lowest_n = activeChannel;
        end
      end
      RELEASE: begin
        hrq_n = 1'b0;
        if (!HLDA) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        hrq_n = 1'b0;
        dack_n = '0;
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      HRQ <= 1'b0;
      DACK <= '0;
      activeChannel <= 2'd0;
      lowest <= 2'd3;
    end else begin
      state <= state_n;
      HRQ <= hrq_n;
      DACK <= dack_n;
      activeChannel <= active_n;
      lowest <= lowest_n;
    end
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: directed self-checking bench for dma_priority_arbiter
module tb_dma_priority_arbiter;
  logic CLK, RESET, rotatePriority, HLDA, serviceDone, HRQ, busy, inv_en;
  logic [3:0] DREQ, maskReg, DACK;
  logic [1:0] activeChannel;
  int n_cmp = 0, n_err = 0;
  logic [3:0] rot_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg),
    .rotatePriority(rotatePriority), .HLDA(HLDA), .serviceDone(serviceDone),
    .HRQ(HRQ), .DACK(DACK), .activeChannel(activeChannel), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic svc(input string tag);
    serviceDone = 1'b1;
    tick();
    chk({tag, "_done_dack"}, 8'(DACK), 8'h0);
    chk({tag, "_done_hrq"}, 8'(HRQ), 8'h0);
    serviceDone = 1'b0;
    HLDA = 1'b0;
    tick();
  endtask

  always @(negedge CLK)
    if (inv_en) begin
      chk("inv_onehot", 8'($onehot0(DACK)), 8'h1);
      chk("inv_dack_hrq", 8'((DACK == 4'b0) || HRQ), 8'h1);
    end

  initial begin
    inv_en = 1'b0;
    RESET = 1'b1;
    DREQ = 4'b0; maskReg = 4'b0; rotatePriority = 1'b0; HLDA = 1'b0; serviceDone = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    tick();
    inv_en = 1'b1;
    chk("rst_hrq", 8'(HRQ), 8'h0);
    chk("rst_dack", 8'(DACK), 8'h0);
    chk("rst_active", 8'(activeChannel), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    // Fixed priority
    DREQ = 4'b1010;
    tick();
    chk("fix_hrq", 8'(HRQ), 8'h1);
    chk("fix_busy", 8'(busy), 8'h1);
    chk("fix_req_dack", 8'(DACK), 8'h0);
    tick();
    chk("fix_wait_dack", 8'(DACK), 8'h0);
    HLDA = 1'b1;
    tick();
    chk("fix_dack", 8'(DACK), 8'h2);
    chk("fix_active", 8'(activeChannel), 8'h1);
    DREQ = 4'b0001;
    tick();
    chk("fix_hold_dack", 8'(DACK), 8'h2);
    DREQ = 4'b1000;
    serviceDone = 1'b1;
    tick();
    chk("fix_done_dack", 8'(DACK), 8'h0);
    chk("fix_done_hrq", 8'(HRQ), 8'h0);
    chk("fix_rel_busy", 8'(busy), 8'h1);
    serviceDone = 1'b0;
    tick();
    chk("fix_rel_hrq", 8'(HRQ), 8'h0);
    HLDA = 1'b0;
    tick();
    chk("fix_idle_hrq", 8'(HRQ), 8'h0);
    tick();
    chk("fix_rereq_hrq", 8'(HRQ), 8'h1);
    HLDA = 1'b1;
    tick();
    chk("fix_dack2", 8'(DACK), 8'h8);
    chk("fix_active2", 8'(activeChannel), 8'h3);
    DREQ = 4'b0;
    svc("fix2");
    // Rotating priority
    rotatePriority = 1'b1;
    DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rot_hrq", 8'(HRQ), 8'h1);
      HLDA = 1'b1;
      tick();
      chk($sformatf("rot_dack%0d", i), 8'(DACK), 8'(rot_seq[i]));
      svc("rot");
    end
    DREQ = 4'b0;
    rotatePriority = 1'b0;
    tick();
    // Late higher-priority request
    DREQ = 4'b0100;
    tick();
    chk("late_hrq", 8'(HRQ), 8'h1);
    DREQ = 4'b0101;
    tick();
    HLDA = 1'b1;
    tick();
    chk("late_dack", 8'(DACK), 8'h1);
    chk("late_active", 8'(activeChannel), 8'h0);
    DREQ = 4'b0;
    svc("late");
    // Masking and withdrawal
    maskReg = 4'b0001;
    DREQ = 4'b0001;
    tick(); tick();
    chk("mask_hrq", 8'(HRQ), 8'h0);
    chk("mask_busy", 8'(busy), 8'h0);
    maskReg = 4'b0000;
    tick();
    chk("wd_hrq", 8'(HRQ), 8'h1);
    DREQ = 4'b0;
    tick();
    chk("wd_hrq_low", 8'(HRQ), 8'h0);
    chk("wd_dack", 8'(DACK), 8'h0);
    chk("wd_busy", 8'(busy), 8'h0);
    // Mask of the active channel during grant
    DREQ = 4'b0010;
    tick();
    HLDA = 1'b1;
    tick();
    chk("mgr_dack", 8'(DACK), 8'h2);
    maskReg = 4'b0010;
    tick();
    chk("mgr_dack_off", 8'(DACK), 8'h0);
    chk("mgr_hrq_off", 8'(HRQ), 8'h0);
    chk("mgr_busy", 8'(busy), 8'h1);
    maskReg = 4'b0;
    DREQ = 4'b0;
    HLDA = 1'b0;
    tick();
    chk("mgr_idle", 8'(busy), 8'h0);
    // Async reset mid-grant
    rotatePriority = 1'b1;
    DREQ = 4'b0100;
    tick();
    HLDA = 1'b1;
    tick();
    chk("ar_dack", 8'(DACK), 8'h4);
    RESET = 1'b1;
    #1;
    chk("ar_hrq", 8'(HRQ), 8'h0);
    chk("ar_dack0", 8'(DACK), 8'h0);
    chk("ar_busy", 8'(busy), 8'h0);
    chk("ar_active", 8'(activeChannel), 8'h0);
    #1;
    RESET = 1'b0;
    HLDA = 1'b0;
    DREQ = 4'b0;
    tick();
    // Bus revoke leaves the rotation pointer alone
    DREQ = 4'b0100;
    tick();
    HLDA = 1'b1;
    tick();
    chk("rev_dack", 8'(DACK), 8'h4);
    HLDA = 1'b0;
    tick();
    chk("rev_dack0", 8'(DACK), 8'h0);
    chk("rev_hrq0", 8'(HRQ), 8'h0);
    chk("rev_idle", 8'(busy), 8'h0);
    DREQ = 4'b1101;
    tick();
    HLDA = 1'b1;
    tick();
    chk("rev_next_dack", 8'(DACK), 8'h1);
    // Completion coinciding with HLDA drop goes straight to idle and rotates
    serviceDone = 1'b1;
    HLDA = 1'b0;
    tick();
    serviceDone = 1'b0;
    chk("sdh_busy", 8'(busy), 8'h0);
    chk("sdh_dack", 8'(DACK), 8'h0);
    tick();
    chk("sdh_hrq", 8'(HRQ), 8'h1);
    HLDA = 1'b1;
    tick();
    chk("sdh_rot_dack", 8'(DACK), 8'h4);
    DREQ = 4'b0;
    svc("end");
    inv_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Four-channel DMA request arbiter sitting between the DREQ pins and the DMA timing-and-control state machine. It resolves unmasked channel requests under fixed or rotating priority and runs the HRQ/HLDA bus-hold handshake with the host CPU. It drives one-hot DACK for the winning channel and holds it until the timing block reports end of service. Channel number and busy flag go to timing-and-control to select address/count registers.

## Interface
- NUM_CH, 4: channel count; only 4 is supported; DREQ/DACK width.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DREQ  in  NUM_CH  channel requests, active-high, level-sensitive.
- maskReg  in  NUM_CH  per-channel mask, 1 = channel ignored.
- rotatePriority  in  1  0 = fixed priority (ch0 highest), 1 = rotating.
- HLDA  in  1  hold acknowledge from CPU, active-high.
- serviceDone  in  1  one-cycle pulse from timing-and-control: current channel's service finished (TC, EOP or single transfer).
- HRQ  out  1  hold request to CPU, registered.
- DACK  out  NUM_CH  one-hot acknowledge, registered, active-high.
- activeChannel  out  2  granted channel index, registered.
- busy  out  1  high in REQ, GRANT, RELEASE.

## Operation
- Pending vector = DREQ & ~maskReg.
- Priority pointer lowestCh (2 bits): search order lowestCh+1, +2, +3, lowestCh (mod 4). Fixed mode uses lowestCh = 3 regardless of the register, so order is 0,1,2,3.
- States: IDLE, REQ, GRANT, RELEASE.
- IDLE: if pending != 0, go REQ, HRQ <= 1. Otherwise stay, HRQ = 0, DACK = 0.
- REQ: HRQ held 1. Priority is re-resolved every cycle, so a higher-priority request arriving before HLDA wins.
  - If pending == 0: HRQ <= 0, go IDLE (request withdrawn).
  - If HLDA == 1 and pending != 0: latch winner into activeChannel, DACK <= onehot(winner), go GRANT.
- GRANT: DACK and activeChannel held constant; DREQ changes on any channel are ignored.
  - serviceDone == 1: DACK <= 0, HRQ <= 0. If rotatePriority, lowestCh <= activeChannel. Go RELEASE.
  - maskReg[activeChannel] set: same as serviceDone, except lowestCh is not updated.
  - HLDA drops (bus revoked): DACK <= 0, HRQ <= 0, go IDLE. lowestCh is not updated.
- RELEASE: HRQ = 0. Wait for HLDA == 0, then go IDLE. A new request is never raised before HLDA is low.
- Simultaneous events in GRANT:
  - serviceDone with HLDA drop: treated as completion, lowestCh updated, go IDLE directly.
  - serviceDone with mask set: treated as completion.
- rotatePriority changing 1→0 does not clear lowestCh. The register resumes use when rotation is re-enabled.
- Illegal state encoding recovers to IDLE with all outputs 0.

## Timing
- Reset (async assert, sync-safe release): state = IDLE, HRQ = 0, DACK = 0000, activeChannel = 0, busy = 0, lowestCh = 3.
- DREQ (unmasked) sampled high at edge N → HRQ high after edge N.
- HLDA sampled high at edge M in REQ → DACK/activeChannel valid after edge M. The winner is decided from pending at edge M.
- serviceDone at edge K → DACK = 0 and HRQ = 0 after edge K.
- First HLDA-low edge in RELEASE → IDLE. The earliest new HRQ is at the following edge.
- Minimum back-to-back grant gap: 2 cycles of HRQ low when HLDA follows HRQ immediately.
- DACK is always one-hot or zero and is never nonzero while HLDA = 0 or HRQ = 0 (assertion target).

## Test plan
- Reset: assert RESET mid-GRANT with DACK = 0100 → outputs HRQ = 0, DACK = 0000, busy = 0 immediately, before the next CLK edge.
- Fixed priority: DREQ = 1010, mask = 0, HLDA raised 2 cycles after HRQ → DACK = 0010, activeChannel = 1. After serviceDone and HLDA low, the next grant is DACK = 1000.
- Rotating priority: rotatePriority = 1, DREQ = 1111 held, four full services → DACK sequence 0001, 0010, 0100, 1000, 0001.
- Late higher request: DREQ = 0100 raises HRQ; DREQ[0] rises before HLDA → grant DACK = 0001.
- Masking and withdrawal: DREQ = 0001 with maskReg = 0001 → HRQ stays 0. DREQ drops in REQ → HRQ falls next cycle, return to IDLE with no DACK.
- Bus revoke: HLDA drops in GRANT on ch2 with rotatePriority = 1 → DACK = 0000 next cycle, lowestCh unchanged (still 3), next winner under DREQ = 0101 is ch0.
